// File: rtl/writeback_buffer.sv
// writeback_buffer
// Holds evicted dirty 64-byte cache lines until the line-write engine has
// burst them onto Mybus. Lines drain in FIFO order, one in flight at a time,
// over a stable-hold request/complete handshake. Every queued line, including
// the one in flight, stays visible to the read-forwarding lookup port. A
// re-eviction of a line that is already queued (and not in flight) overwrites
// that entry's data instead of taking a new slot.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enq_valid/enq_ready        evicted line handshake (enq_ready combinational)
//   enq_addr, enq_data         line address ([5:0] ignored) and 64 bytes of data
//   lookup_addr                read-miss address to check ([5:0] ignored)
//   lookup_hit, lookup_data    match flag and youngest matching data (0 on miss)
//   wr_reqcyc                  registered write request to the write engine
//   wr_addr, wr_data           head line address/data, 0 while wr_reqcyc is low
//   wr_respcyc                 one-cycle burst-complete pulse
//   count, empty               occupancy, including the in-flight head
module writeback_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [63:0]              enq_addr,
  input  logic [0:511]             enq_data,
  input  logic [63:0]              lookup_addr,
  output logic                     lookup_hit,
  output logic [0:511]             lookup_data,
  output logic                     wr_reqcyc,
  output logic [63:0]              wr_addr,
  output logic [0:511]             wr_data,
  input  logic                     wr_respcyc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [DEPTH-1:0]  valid;
  logic [63:6]       line_addr [DEPTH];
  logic [0:511]      data_mem  [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic              merge_hit;
  logic [PW-1:0]     merge_idx;
  logic [PW-1:0]     lk_idx;
  logic              accept;
  logic              alloc;
  logic              pop;
  logic [PW:0]       count_next;

  wire logic unused_low_bits = ^{enq_addr[5:0], lookup_addr[5:0]};

  // Merge target: any valid entry with the same line, except the in-flight head.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && line_addr[i] == enq_addr[63:6] &&
          !(state == BUSY && PW'(i) == head)) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      lk_idx = head + PW'(k);
      if (valid[lk_idx] && line_addr[lk_idx] == lookup_addr[63:6]) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[lk_idx];
      end
    end
  end

  assign enq_ready = merge_hit || (count != FULL);
  assign accept    = enq_valid && enq_ready;
  assign alloc     = accept && !merge_hit;
  assign pop       = (state == BUSY) && wr_respcyc;

  always_comb begin
    count_next = count;
    if (alloc && !pop)      count_next = count + 1'b1;
    else if (!alloc && pop) count_next = count - 1'b1;
  end

  assign empty = (count == '0);

  // Head is never written while BUSY, so reading storage directly keeps
  // wr_addr/wr_data stable for the whole request, and also picks up a merge
  // into the head that lands on the same edge as the IDLE->BUSY transition.
  assign wr_addr = wr_reqcyc ? {line_addr[head], 6'b0} : '0;
  assign wr_data = wr_reqcyc ? data_mem[head] : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      if (merge_hit) begin
        data_mem[merge_idx] <= enq_data;
      end else begin
        line_addr[tail] <= enq_addr[63:6];
        data_mem[tail]  <= enq_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state     <= IDLE;
      wr_reqcyc <= 1'b0;
    end else begin
      count <= count_next;
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= BUSY;
            wr_reqcyc <= 1'b1;
          end
        end
        BUSY: begin
          if (wr_respcyc) begin
            state     <= IDLE;
            wr_reqcyc <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          wr_reqcyc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Testbench for writeback_buffer: directed scenarios followed by a random
// phase, all checked against a queue-based reference model of the buffer.
module tb_writeback_buffer;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enq_valid;
  logic                   enq_ready;
  logic [63:0]            enq_addr;
  logic [0:511]           enq_data;
  logic [63:0]            lookup_addr;
  logic                   lookup_hit;
  logic [0:511]           lookup_data;
  logic                   wr_reqcyc;
  logic [63:0]            wr_addr;
  logic [0:511]           wr_data;
  logic                   wr_respcyc;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;

  writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .wr_reqcyc(wr_reqcyc), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_respcyc(wr_respcyc), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue front is the oldest line; busy means front is in flight.
  typedef struct {
    logic [57:0]  line;
    logic [0:511] data;
  } ent_t;
  ent_t q[$];
  bit   busy = 1'b0;

  function automatic int m_merge(logic [63:0] a);
    for (int i = (busy ? 1 : 0); i < q.size(); i++)
      if (q[i].line == a[63:6]) return i;
    return -1;
  endfunction

  function automatic bit m_ready(logic [63:0] a);
    return (m_merge(a) >= 0) || (q.size() < DEPTH);
  endfunction

  function automatic int m_lookup(logic [63:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].line == a[63:6]) return i;
    return -1;
  endfunction

  function automatic logic [0:511] pat(logic [7:0] base);
    logic [0:511] d;
    for (int b = 0; b < 64; b++) d[b*8 +: 8] = base + 8'(b);
    return d;
  endfunction

  function automatic logic [0:511] rnd_data();
    logic [0:511] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs before the
  // edge, advance the model on the edge, check registered outputs after it.
  task automatic step(input logic ev, input logic [63:0] ea, input logic [0:511] ed,
                      input logic resp, input logic [63:0] la, input logic rst);
    int mi, li, psize;
    bit pbusy, rdy;
    ent_t e;
    @(negedge clk);
    enq_valid = ev; enq_addr = ea; enq_data = ed;
    wr_respcyc = resp; lookup_addr = la; reset = rst;
    #1;
    mi  = m_merge(ea);
    rdy = m_ready(ea);
    li  = m_lookup(la);
    chk("enq_ready", enq_ready, rdy);
    chk("lookup_hit", lookup_hit, li >= 0);
    chk("lookup_data", lookup_data, (li >= 0) ? q[li].data : '0);
    @(posedge clk);
    psize = q.size();
    pbusy = busy;
    if (rst) begin
      q.delete();
      busy = 1'b0;
    end else begin
      if (ev && rdy) begin
        if (mi >= 0) begin
          e = q[mi]; e.data = ed; q[mi] = e;
        end else begin
          e.line = ea[63:6]; e.data = ed; q.push_back(e);
        end
      end
      if (pbusy && resp) void'(q.pop_front());
      busy = pbusy ? !resp : (psize > 0);
    end
    #1;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("wr_reqcyc", wr_reqcyc, busy);
    chk("wr_addr", wr_addr, busy ? {q[0].line, 6'b0} : 64'd0);
    chk("wr_data", wr_data, busy ? q[0].data : '0);
  endtask

  task automatic idle_cycle(input logic resp);
    step(1'b0, 64'd0, '0, resp, 64'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH + 2; i++) idle_cycle(1'b1);
  endtask

  logic [0:511] da, db, dc, dd, de;

  initial begin
    enq_valid = 0; enq_addr = '0; enq_data = '0;
    wr_respcyc = 0; lookup_addr = '0; reset = 1;

    // Reset
    step(1'b0, 64'd0, '0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 64'd0, '0, 1'b1, 64'd0, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_wr_reqcyc", wr_reqcyc, 0);
    chk("rst_lookup_hit", lookup_hit, 0);

    // Single line
    da = pat(8'h00);
    step(1'b1, 64'h1040, da, 1'b0, 64'h1040, 1'b0);
    chk("single_count", count, 1);
    chk("single_req_latency", wr_reqcyc, 0);
    idle_cycle(1'b0);
    chk("single_wr_addr", wr_addr, 64'h1040);
    chk("single_wr_data", wr_data, da);
    idle_cycle(1'b1);
    chk("single_done_empty", empty, 1);
    chk("single_done_req", wr_reqcyc, 0);

    // Fill and back-pressure
    for (int i = 0; i < 4; i++)
      step(1'b1, 64'(i * 64), pat(8'(i * 16)), 1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h100, pat(8'h80), 1'b0, 64'h100, 1'b0);
    chk("full_not_ready", enq_ready, 0);
    step(1'b1, 64'h100, pat(8'h80), 1'b1, 64'h100, 1'b0);
    chk("full_pop_count", count, 3);
    chk("full_pop_gap", wr_reqcyc, 0);
    step(1'b1, 64'h100, pat(8'h80), 1'b0, 64'h040, 1'b0);
    chk("full_next_head", wr_addr, 64'h040);
    chk("full_accept_count", count, 4);
    drain();

    // Merge
    da = pat(8'h11); db = pat(8'h22); dc = pat(8'h33);
    step(1'b1, 64'h200, da, 1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h240, db, 1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h27F, '1, 1'b0, 64'h240, 1'b0);
    chk("merge_count", count, 2);
    step(1'b1, 64'h200, dc, 1'b0, 64'h200, 1'b0);
    chk("merge_head_alloc", count, 3);
    chk("merge_head_stable", wr_data, da);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    chk("merge_burst_data", wr_data, '1);
    drain();

    // Lookup
    dd = pat(8'h44); de = pat(8'h55);
    step(1'b1, 64'h300, dd, 1'b0, 64'h0, 1'b0);
    idle_cycle(1'b0);
    step(1'b1, 64'h300, de, 1'b0, 64'h300, 1'b0);
    lookup_addr = 64'h310; #1;
    chk("lookup_young_hit", lookup_hit, 1);
    chk("lookup_young_data", lookup_data, de);
    lookup_addr = 64'h340; #1;
    chk("lookup_miss_hit", lookup_hit, 0);
    chk("lookup_miss_data", lookup_data, '0);
    drain();

    // Wrap with enqueue coinciding with completion
    begin
      int n = 0;
      for (int k = 0; k < 80 && n < 10; k++) begin
        bit r = m_ready(64'h400 + 64'(n * 64));
        step(1'b1, 64'h400 + 64'(n * 64), pat(8'(n * 7)), busy, 64'h400 + 64'(n * 64), 1'b0);
        if (r) n++;
      end
      chk("wrap_all_accepted", n, 10);
      for (int k = 0; k < 30; k++) step(1'b0, 64'd0, '0, busy, 64'h400 + 64'((k % 10) * 64), 1'b0);
      chk("wrap_drained", empty, 1);
    end

    // Reset mid-burst, then stray completion in IDLE
    for (int i = 0; i < 3; i++) step(1'b1, 64'h500 + 64'(i * 64), pat(8'(i)), 1'b0, 64'h0, 1'b0);
    chk("pre_reset_count", count, 3);
    chk("pre_reset_busy", wr_reqcyc, 1);
    step(1'b0, 64'd0, '0, 1'b0, 64'h500, 1'b1);
    chk("mid_reset_count", count, 0);
    chk("mid_reset_req", wr_reqcyc, 0);
    chk("mid_reset_ready", enq_ready, 1);
    step(1'b1, 64'h600, pat(8'h66), 1'b0, 64'h0, 1'b0);
    idle_cycle(1'b1);
    chk("stray_resp_count", count, 1);
    chk("stray_resp_req", wr_reqcyc, 1);
    drain();

    // Random
    for (int k = 0; k < 400; k++) begin
      logic [63:0] a, l;
      a = 64'h7000 + 64'($urandom_range(0, 5) * 64) + 64'($urandom_range(0, 63));
      l = 64'h7000 + 64'($urandom_range(0, 6) * 64) + 64'($urandom_range(0, 63));
      step(($urandom_range(0, 99) < 60), a, rnd_data(), ($urandom_range(0, 2) == 0),
           l, ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
